// File: rtl/testport_snoop_fifo_if.sv
// Bus between the memory-side snooper and the result checker.
// The snooper takes the slave modport; the bench or upstream logic takes master.
interface testport_snoop_fifo_if #(
    parameter int CNT_W = 4
);
    // Snoop side: mem_wen may be held for several cycles during a stall.
    logic [29:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             mem_wen;

    // Checker side valid/ready: the head entry (out_data/out_last/out_ts) is
    // stable while out_valid=1 and out_ready=0; it is consumed on the rising
    // clock edge where out_valid & out_ready are both high; out_ready may be
    // high while out_valid is low, which has no effect.
    logic             out_valid;
    logic [31:0]      out_data;
    logic             out_last;
    logic             out_ready;
    logic [15:0]      out_ts;

    // Status
    logic             active;
    logic             done;
    logic             overflow;
    logic [7:0]       drop_cnt;
    logic [CNT_W-1:0] count;

    modport master (
        output mem_addr, mem_wdata, mem_wen, out_ready,
        input  out_valid, out_data, out_last, out_ts,
        input  active, done, overflow, drop_cnt, count
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_wen, out_ready,
        output out_valid, out_data, out_last, out_ts,
        output active, done, overflow, drop_cnt, count
    );
endinterface

// File: rtl/testport_snoop_fifo.sv
// Test-port write snooper: edge-detects stores, frames a BEGIN..END session, buffers in a FWFT FIFO.
// Optional per-entry session timestamps are enabled with `define TESTPORT_TS_EN.
module testport_snoop_fifo #(
    parameter logic [29:0] TEST_PORT = 30'h3FF,
    parameter logic [31:0] BEGIN_SYM = 32'h00000168,
    parameter logic [31:0] END_SYM   = 32'hFFFFFD5D,
    parameter int          DEPTH     = 8,
    parameter int          CNT_W     = 4
) (
    input logic                  clk,
    input logic                  rst,
    testport_snoop_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             wen_q;
    logic [31:0]      sw;
    logic             evt;
    logic             open_evt;
    logic             pop;
    logic             push;
    logic             drop;
    logic             full;

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic [7:0]       drop_cnt_q;
    logic [31:0]      data_mem [DEPTH];
    logic             last_mem [DEPTH];

    always_comb begin
        sw       = {bus.mem_wdata[7:0], bus.mem_wdata[15:8],
                    bus.mem_wdata[23:16], bus.mem_wdata[31:24]};
        // Rising edge of wen: a stalled write held for N cycles is one event.
        evt      = bus.mem_wen & ~wen_q & (bus.mem_addr == TEST_PORT);
        pop      = (count_q != '0) & bus.out_ready;
        full     = (count_q >= CNT_W'(DEPTH));
        state_d  = state_q;
        open_evt = 1'b0;
        push     = 1'b0;
        drop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (evt && (sw == BEGIN_SYM)) begin
                    state_d  = CAPTURE;
                    open_evt = 1'b1;
                end
            end
            CAPTURE: begin
                if (evt) begin
                    // A full FIFO still takes the entry if the head leaves this cycle.
                    if (!full || pop) push = 1'b1;
                    else              drop = 1'b1;
                    if (sw == END_SYM) state_d = DONE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wen_q   <= bus.mem_wen;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    // Storage is not reset; the head is masked by out_valid instead.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= sw;
            last_mem[wr_ptr_q] <= (sw == END_SYM);
        end
    end

`ifdef TESTPORT_TS_EN
    logic [15:0] ts_q;
    logic [15:0] ts_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     ts_q <= '0;
        else if (open_evt)           ts_q <= '0;
        else if (state_q == CAPTURE) ts_q <= ts_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (push) ts_mem[wr_ptr_q] <= ts_q;
    end

    assign bus.out_ts = bus.out_valid ? ts_mem[rd_ptr_q] : 16'd0;
`else
    assign bus.out_ts = 16'd0;
`endif

    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = bus.out_valid ? data_mem[rd_ptr_q] : 32'd0;
    assign bus.out_last  = bus.out_valid & last_mem[rd_ptr_q];
    assign bus.active    = (state_q == CAPTURE);
    assign bus.done      = (state_q == DONE);
    assign bus.overflow  = overflow_q;
    assign bus.drop_cnt  = drop_cnt_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_testport_snoop_fifo.sv
// Bench for testport_snoop_fifo: directed scenarios plus random traffic checked every cycle
// against a queue-based model of the snooper.
module tb_testport_snoop_fifo;
    localparam logic [29:0] TP        = 30'h3FF;
    localparam logic [31:0] BEGIN_SYM = 32'h00000168;
    localparam logic [31:0] END_SYM   = 32'hFFFFFD5D;
    localparam int          DEPTH     = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    testport_snoop_fifo_if #(.CNT_W(4)) bus ();

    testport_snoop_fifo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    function automatic logic [31:0] swap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [15:0] ts;
    } ent_t;

    ent_t exp_q[$];
    bit   m_open, m_closed, m_prev_wen, m_ovf;
    int   m_drops, m_ts;

    always @(posedge clk or posedge rst) begin
        bit          ev;
        logic [31:0] v;
        int          old_ts;
        bit          was_open;
        if (rst) begin
            exp_q.delete();
            m_open = 0; m_closed = 0; m_prev_wen = 0;
            m_ovf = 0; m_drops = 0; m_ts = 0;
        end else begin
            v          = swap(bus.mem_wdata);
            ev         = bus.mem_wen && !m_prev_wen && (bus.mem_addr == TP);
            m_prev_wen = bus.mem_wen;
            old_ts     = m_ts;
            was_open   = m_open;
            if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
            if (ev && !m_open && !m_closed) begin
                if (v == BEGIN_SYM) begin
                    m_open = 1;
                    m_ts   = 0;
                end
            end else if (ev && m_open) begin
                if (exp_q.size() < DEPTH) begin
                    exp_q.push_back('{data: v, last: (v == END_SYM), ts: 16'(old_ts)});
                end else begin
                    m_ovf   = 1;
                    m_drops = (m_drops < 255) ? m_drops + 1 : 255;
                end
                if (v == END_SYM) begin
                    m_open   = 0;
                    m_closed = 1;
                end
            end
            if (was_open) m_ts = (old_ts + 1) & 16'hFFFF;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [15:0] exp_ts;
        if (chk_en) begin
            check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
`ifdef TESTPORT_TS_EN
                exp_ts = exp_q[0].ts;
`else
                exp_ts = 16'd0;
`endif
                check("out_data", bus.out_data, exp_q[0].data);
                check("out_last", 32'(bus.out_last), 32'(exp_q[0].last));
                check("out_ts", 32'(bus.out_ts), 32'(exp_ts));
            end
            check("count", 32'(bus.count), 32'(exp_q.size()));
            check("active", 32'(bus.active), 32'(m_open));
            check("done", 32'(bus.done), 32'(m_closed));
            check("overflow", 32'(bus.overflow), 32'(m_ovf));
            check("drop_cnt", 32'(bus.drop_cnt), 32'(m_drops));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [29:0] a, input logic [31:0] d, input int hold);
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        bus.mem_wen   = 1'b1;
        repeat (hold) tick();
        bus.mem_wen = 1'b0;
        tick();
    endtask

    task automatic put(input logic [31:0] readable);
        wr(TP, swap(readable), 1);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.mem_wen   = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst           = 1'b1;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wen   = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        chk_en = 1'b1;

        // Reset values
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", bus.out_data, 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_active", 32'(bus.active), 32'd0);
        check("rst_ts", 32'(bus.out_ts), 32'd0);
        rst = 1'b0;
        tick();

        // Stalled BEGIN collapses to one event, then one data write
        do_reset();
        wr(TP, 32'h68010000, 3);
        wr(TP, 32'h05000000, 1);
        check("t1_active", 32'(bus.active), 32'd1);
        check("t1_count", 32'(bus.count), 32'd1);
        check("t1_data", bus.out_data, 32'd5);

        // Ten writes into eight entries, then drain
        do_reset();
        put(BEGIN_SYM);
        for (int i = 1; i <= 10; i++) put(32'(i));
        check("t2_count", 32'(bus.count), 32'd8);
        check("t2_overflow", 32'(bus.overflow), 32'd1);
        check("t2_drops", 32'(bus.drop_cnt), 32'd2);
        check("t2_head", bus.out_data, 32'd1);
        bus.out_ready = 1'b1;
        repeat (7) tick();
        check("t2_tail", bus.out_data, 32'd8);
        tick();
        bus.out_ready = 1'b0;
        check("t2_empty", 32'(bus.count), 32'd0);

        // Full FIFO with simultaneous pop and push
        do_reset();
        put(BEGIN_SYM);
        for (int i = 1; i <= 8; i++) put(32'(i + 16));
        check("t3_full", 32'(bus.count), 32'd8);
        bus.out_ready = 1'b1;
        bus.mem_wdata = swap(32'd99);
        bus.mem_wen   = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.mem_wen   = 1'b0;
        tick();
        check("t3_count", 32'(bus.count), 32'd8);
        check("t3_overflow", 32'(bus.overflow), 32'd0);
        check("t3_head", bus.out_data, 32'd18);

        // END closes the session; later writes ignored
        do_reset();
        put(BEGIN_SYM);
        wr(TP, 32'h5DFDFFFF, 1);
        check("t4_last", 32'(bus.out_last), 32'd1);
        check("t4_done", 32'(bus.done), 32'd1);
        check("t4_active", 32'(bus.active), 32'd0);
        put(32'd7);
        put(BEGIN_SYM);
        check("t4_count", 32'(bus.count), 32'd1);

        // Asynchronous reset mid-session
        do_reset();
        put(BEGIN_SYM);
        for (int i = 1; i <= 5; i++) put(32'(i));
        check("t5_count5", 32'(bus.count), 32'd5);
        rst = 1'b1;
        #1;
        check("t5_count", 32'(bus.count), 32'd0);
        check("t5_valid", 32'(bus.out_valid), 32'd0);
        check("t5_active", 32'(bus.active), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        put(32'd3);
        put(32'd4);
        check("t5_ignored", 32'(bus.count), 32'd0);
        check("t5_idle", 32'(bus.active), 32'd0);

        // Timestamp: data sampled four edges after BEGIN
        do_reset();
        bus.mem_addr  = TP;
        bus.mem_wdata = swap(BEGIN_SYM);
        bus.mem_wen   = 1'b1;
        tick();
        bus.mem_wen = 1'b0;
        repeat (3) tick();
        wr(TP, swap(32'd42), 1);
        check("t6_data", bus.out_data, 32'd42);
`ifdef TESTPORT_TS_EN
        check("t6_ts", 32'(bus.out_ts), 32'd3);
`else
        check("t6_ts", 32'(bus.out_ts), 32'd0);
`endif

        // Random traffic with stalls, stray addresses and back-pressure
        for (int s = 0; s < 10; s++) begin
            do_reset();
            if (s % 3 != 2) put(BEGIN_SYM);
            for (int c = 0; c < 300; c++) begin
                bus.out_ready = ($urandom_range(0, 3) != 0) && (s % 2 == 0 || $urandom_range(0, 1) == 1);
                if (!(bus.mem_wen && $urandom_range(0, 2) != 0)) begin
                    int r;
                    bus.mem_wen  = $urandom_range(0, 1) == 1;
                    bus.mem_addr = ($urandom_range(0, 5) == 0) ? 30'($urandom) : TP;
                    r = int'($urandom_range(0, 99));
                    if (r < 3)       bus.mem_wdata = swap(BEGIN_SYM);
                    else if (r < 5)  bus.mem_wdata = swap(END_SYM);
                    else             bus.mem_wdata = $urandom;
                end
                tick();
            end
        end

        bus.mem_wen   = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
